// File: rtl/ahb_apb_bridge_if.sv
// Bus bundle for the AHB-Lite to APB3 bridge: AHB responder signals and the APB initiator signals.
// The slave modport is the bridge's view; master is the surrounding system (decoder, mux, peripherals).
interface ahb_apb_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned APB_SLAVES = 4
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [1:0]            HTRANS;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [DATA_WIDTH-1:0] HRDATA;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic [APB_SLAVES-1:0] PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA, PRDATA, PREADY, PSLVERR,
        output HREADYOUT, HRESP, HRDATA, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY, HWDATA, PRDATA, PREADY, PSLVERR,
        input  HREADYOUT, HRESP, HRDATA, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite responder converting single transfers into APB3 SETUP/ACCESS sequences; PSLVERR and
// misaligned accesses become the two-cycle AHB ERROR response. All outputs come straight from flops.
module ahb_apb_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned APB_SLAVES = 4
) (
    input logic             HCLK,
    input logic             HRESETn,
    ahb_apb_bridge_if.slave bus
);
    localparam int unsigned IdxWidth = (APB_SLAVES > 1) ? $clog2(APB_SLAVES) : 1;

    typedef enum logic [2:0] {
        StIdle, StWdata, StSetup, StAccess, StResp, StErr1, StErr2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic [APB_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;

    logic                  xfer_start;
    logic                  misaligned;
    logic [IdxWidth-1:0]   idx;
    logic                  unused_htrans0;

    assign unused_htrans0 = bus.HTRANS[0];

    always_comb begin
        xfer_start = (state_q inside {StIdle, StResp, StErr2}) &&
                     bus.HSEL && bus.HREADY && bus.HTRANS[1];
        misaligned = (bus.HSIZE > 3'd2) ||
                     ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00)) ||
                     ((bus.HSIZE == 3'd1) && bus.HADDR[0]);
    end

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;

        unique case (state_q)
            StIdle, StResp, StErr2: begin
                if (xfer_start) begin
                    paddr_d  = bus.HADDR;
                    pwrite_d = bus.HWRITE;
                    if (misaligned) begin
                        state_d = StErr1;
                    end else if (bus.HWRITE) begin
                        state_d = StWdata;
                    end else begin
                        state_d = StSetup;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWdata: begin
                pwdata_d = bus.HWDATA;
                state_d  = StSetup;
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (bus.PREADY) begin
                    if (!pwrite_q) begin
                        hrdata_d = bus.PRDATA;
                    end
                    state_d = bus.PSLVERR ? StErr1 : StResp;
                end
            end
            StErr1: state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    // Output flops are loaded from the next state so every output is registered.
    always_comb begin
        idx    = (APB_SLAVES > 1) ? paddr_d[12 +: IdxWidth] : '0;
        psel_d = '0;
        if (state_d inside {StSetup, StAccess}) begin
            for (int i = 0; i < int'(APB_SLAVES); i++) begin
                psel_d[i] = (idx == IdxWidth'(i));
            end
        end
        penable_d   = (state_d == StAccess);
        hreadyout_d = (state_d inside {StIdle, StResp, StErr2});
        hresp_d     = (state_d inside {StErr1, StErr2});
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Scoreboard bench for ahb_apb_bridge: directed AHB transfers push expected responses, and
// negedge monitors pop and compare AHB completions and APB SETUP/ACCESS phases.
module tb_ahb_apb_bridge;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NS = 4;
    localparam logic [1:0] TrIdle = 2'b00, TrBusy = 2'b01, TrNonseq = 2'b10;

    typedef struct {
        logic        resp;
        int          waits;
        int          errw;
        logic        chk_rd;
        logic [31:0] rdata;
    } ahb_exp_t;

    typedef struct {
        logic [3:0]  psel;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
    } apb_exp_t;

    logic HCLK = 1'b0;
    logic HRESETn;
    always #5 HCLK = ~HCLK;

    ahb_apb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .APB_SLAVES(NS)) bus ();

    ahb_apb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .APB_SLAVES(NS)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    // Single-slave system: the bus-wide HREADY is the bridge's own HREADYOUT.
    assign bus.HREADY = bus.HREADYOUT;

    // APB peripheral model: PREADY low for pready_wait ACCESS cycles.
    int          pready_wait = 0;
    logic        perr = 1'b0;
    logic [31:0] prdata_cfg = '0;
    int          acc_cnt;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) acc_cnt <= 0;
        else if (bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign bus.PREADY  = bus.PENABLE && (acc_cnt >= pready_wait);
    assign bus.PSLVERR = bus.PREADY && perr;
    assign bus.PRDATA  = prdata_cfg;

    ahb_exp_t ahb_q[$];
    apb_exp_t apb_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // AHB response monitor.
    initial begin
        logic     in_dp;
        int       waits;
        int       errw;
        ahb_exp_t e;
        in_dp = 1'b0;
        waits = 0;
        errw  = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                in_dp = 1'b0;
            end else begin
                if (in_dp) begin
                    if (!bus.HREADYOUT) begin
                        waits++;
                        if (bus.HRESP) errw++;
                        if (waits > 60) begin
                            chk("ahb_wait_bound", waits, 60);
                            in_dp = 1'b0;
                        end
                    end else begin
                        chk("ahb_resp_expected", ahb_q.size() != 0, 1);
                        if (ahb_q.size() != 0) begin
                            e = ahb_q.pop_front();
                            chk("hresp", bus.HRESP, e.resp);
                            chk("wait_states", waits, e.waits);
                            chk("error_first_cycles", errw, e.errw);
                            if (e.chk_rd) chk("hrdata", bus.HRDATA, e.rdata);
                        end
                        in_dp = 1'b0;
                    end
                end
                if (bus.HSEL && bus.HREADYOUT) begin
                    in_dp = 1'b1;
                    waits = 0;
                    errw  = 0;
                end
            end
        end
    end

    // APB phase monitor: SETUP contents vs expectation, ACCESS stability vs SETUP.
    initial begin
        apb_exp_t a;
        apb_exp_t snap;
        snap = '{psel: '0, paddr: '0, pwrite: 1'b0, pwdata: '0};
        forever begin
            @(negedge HCLK);
            if (HRESETn && bus.PSEL != '0) begin
                if (!bus.PENABLE) begin
                    chk("apb_setup_expected", apb_q.size() != 0, 1);
                    if (apb_q.size() != 0) begin
                        a = apb_q.pop_front();
                        chk("psel", bus.PSEL, a.psel);
                        chk("paddr", bus.PADDR, a.paddr);
                        chk("pwrite", bus.PWRITE, a.pwrite);
                        if (a.pwrite) chk("pwdata", bus.PWDATA, a.pwdata);
                        snap = a;
                    end
                end else begin
                    chk("apb_access_stable", {bus.PSEL, bus.PADDR, bus.PWRITE},
                        {snap.psel, snap.paddr, snap.pwrite});
                    if (snap.pwrite) chk("pwdata_stable", bus.PWDATA, snap.pwdata);
                end
            end
        end
    end

    // Waits for a free address-phase slot, drives one address phase, then the write data phase.
    task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [1:0] trans, input logic [31:0] wdata, input int pw,
                         input logic pe, input logic [31:0] prd, input ahb_exp_t ea,
                         input logic [3:0] epsel);
        int g = 0;
        while (bus.HREADYOUT !== 1'b1 && g < 100) begin
            @(posedge HCLK);
            #1;
            g++;
        end
        chk("issue_slot_ready", bus.HREADYOUT, 1);
        bus.HSEL    = 1'b1;
        bus.HADDR   = addr;
        bus.HWRITE  = wr;
        bus.HSIZE   = size;
        bus.HTRANS  = trans;
        pready_wait = pw;
        perr        = pe;
        prdata_cfg  = prd;
        ahb_q.push_back(ea);
        if (epsel != '0) begin
            apb_q.push_back('{psel: epsel, paddr: addr, pwrite: wr, pwdata: wdata});
        end
        @(posedge HCLK);
        #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = TrIdle;
        if (wr && trans[1]) bus.HWDATA = wdata;
    endtask

    task automatic drain();
        int g = 0;
        while ((ahb_q.size() != 0 || bus.HREADYOUT !== 1'b1) && g < 100) begin
            @(posedge HCLK);
            #1;
            g++;
        end
        chk("drain_ahb_q_empty", ahb_q.size(), 0);
        chk("drain_apb_q_empty", apb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        HRESETn    = 1'b0;
        bus.HSEL   = 1'b0;
        bus.HADDR  = '0;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'd0;
        bus.HTRANS = TrIdle;
        bus.HWDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_hreadyout", bus.HREADYOUT, 1);
        chk("rst_hresp", bus.HRESP, 0);
        chk("rst_hrdata", bus.HRDATA, 0);
        chk("rst_paddr", bus.PADDR, 0);
        chk("rst_psel", bus.PSEL, 0);
        chk("rst_penable", bus.PENABLE, 0);
        chk("rst_pwrite", bus.PWRITE, 0);
        chk("rst_pwdata", bus.PWDATA, 0);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // Aligned read, slave 2, zero-wait peripheral.
        issue(32'h0000_2004, 1'b0, 3'd2, TrNonseq, '0, 0, 1'b0, 32'hCAFE_F00D,
              '{resp: 1'b0, waits: 2, errw: 0, chk_rd: 1'b1, rdata: 32'hCAFE_F00D}, 4'b0100);
        // Write with 3 PREADY-low cycles; HRDATA keeps the last read value.
        issue(32'h0000_1000, 1'b1, 3'd2, TrNonseq, 32'h1234_5678, 3, 1'b0, 32'h0,
              '{resp: 1'b0, waits: 6, errw: 0, chk_rd: 1'b1, rdata: 32'hCAFE_F00D}, 4'b0010);
        // PSLVERR on a read of slave 3 after one wait cycle.
        issue(32'h0000_3010, 1'b0, 3'd2, TrNonseq, '0, 1, 1'b1, 32'hDEAD_0000,
              '{resp: 1'b1, waits: 4, errw: 1, chk_rd: 1'b0, rdata: '0}, 4'b1000);
        // Misaligned word, halfword and oversize: two-cycle ERROR, no APB.
        issue(32'h0000_0002, 1'b0, 3'd2, TrNonseq, '0, 0, 1'b0, '0,
              '{resp: 1'b1, waits: 1, errw: 1, chk_rd: 1'b0, rdata: '0}, 4'b0000);
        issue(32'h0000_0101, 1'b1, 3'd1, TrNonseq, 32'h0000_BEEF, 0, 1'b0, '0,
              '{resp: 1'b1, waits: 1, errw: 1, chk_rd: 1'b0, rdata: '0}, 4'b0000);
        issue(32'h0000_0000, 1'b0, 3'd3, TrNonseq, '0, 0, 1'b0, '0,
              '{resp: 1'b1, waits: 1, errw: 1, chk_rd: 1'b0, rdata: '0}, 4'b0000);
        // Back-to-back: write, read issued in its RESP, then IDLE and BUSY transfers.
        issue(32'h0000_0008, 1'b1, 3'd2, TrNonseq, 32'hA5A5_5A5A, 0, 1'b0, '0,
              '{resp: 1'b0, waits: 3, errw: 0, chk_rd: 1'b0, rdata: '0}, 4'b0001);
        issue(32'h0000_1008, 1'b0, 3'd2, TrNonseq, '0, 0, 1'b0, 32'h0BAD_BEEF,
              '{resp: 1'b0, waits: 2, errw: 0, chk_rd: 1'b1, rdata: 32'h0BAD_BEEF}, 4'b0010);
        issue(32'h0000_2000, 1'b0, 3'd2, TrIdle, '0, 0, 1'b0, '0,
              '{resp: 1'b0, waits: 0, errw: 0, chk_rd: 1'b0, rdata: '0}, 4'b0000);
        issue(32'h0000_2000, 1'b0, 3'd2, TrBusy, '0, 0, 1'b0, '0,
              '{resp: 1'b0, waits: 0, errw: 0, chk_rd: 1'b0, rdata: '0}, 4'b0000);
        // High address bits ignored; byte read at an odd address is aligned.
        issue(32'hFFFF_0004, 1'b0, 3'd2, TrNonseq, '0, 0, 1'b0, 32'h7777_1111,
              '{resp: 1'b0, waits: 2, errw: 0, chk_rd: 1'b1, rdata: 32'h7777_1111}, 4'b0001);
        issue(32'h0000_3003, 1'b0, 3'd0, TrNonseq, '0, 0, 1'b0, 32'h0000_00A5,
              '{resp: 1'b0, waits: 2, errw: 0, chk_rd: 1'b1, rdata: 32'h0000_00A5}, 4'b1000);
        drain();

        // Reset pulsed during ACCESS.
        issue(32'h0000_2000, 1'b0, 3'd2, TrNonseq, '0, 5, 1'b0, 32'h5555_AAAA,
              '{resp: 1'b0, waits: 7, errw: 0, chk_rd: 1'b1, rdata: 32'h5555_AAAA}, 4'b0100);
        g = 0;
        while (bus.PENABLE !== 1'b1 && g < 20) begin
            @(posedge HCLK);
            #1;
            g++;
        end
        chk("rst_mid_reached_access", bus.PENABLE, 1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rst_mid_psel", bus.PSEL, 0);
        chk("rst_mid_penable", bus.PENABLE, 0);
        chk("rst_mid_hreadyout", bus.HREADYOUT, 1);
        chk("rst_mid_hresp", bus.HRESP, 0);
        chk("rst_mid_hrdata", bus.HRDATA, 0);
        ahb_q.delete();
        apb_q.delete();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        issue(32'h0000_0010, 1'b0, 3'd2, TrNonseq, '0, 0, 1'b0, 32'h1357_9BDF,
              '{resp: 1'b0, waits: 2, errw: 0, chk_rd: 1'b1, rdata: 32'h1357_9BDF}, 4'b0001);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
